// File: rtl/render_dispatcher_pkg.sv
// rtl/render_dispatcher_pkg.sv - shared widths, engine ids, payload layout and dispatch states
package render_dispatcher_pkg;

    localparam int X_W_DEF     = 8;
    localparam int Y_W_DEF     = 7;
    localparam int COLOR_W_DEF = 3;

    localparam int ENG_TEXT = 0;
    localparam int ENG_RECT = 1;

    // Payload field offsets agreed with the parser and the engines
    localparam int PL_X_LSB     = 0;
    localparam int PL_Y_LSB     = 8;
    localparam int PL_SIZE_LSB  = 15;
    localparam int PL_COLOR_LSB = 31;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_RELEASE = 2'd2
    } disp_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/render_dispatcher_if.sv
// rtl/render_dispatcher_if.sv - draw command channel from the markup parser
interface render_dispatcher_if #(
    parameter int ENG_W     = 1,
    parameter int PAYLOAD_W = 40
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [ENG_W-1:0]     cmd_engine;
    logic [PAYLOAD_W-1:0] cmd_payload;

    modport master (output cmd_valid, output cmd_engine, output cmd_payload, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_engine, input cmd_payload, output cmd_ready);
endinterface

// File: rtl/render_dispatcher_cmd_fifo.sv
// rtl/render_dispatcher_cmd_fifo.sv - synchronous command FIFO with flush, full/empty flags
module render_dispatcher_cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 42
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign rdata   = mem_q[rd_ptr_q];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once count says they are valid
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/render_dispatcher.sv
// rtl/render_dispatcher.sv - queues draw commands, sequences render engines, muxes pixels to VGA
// Optional RENDER_CLIP_EN suppresses plots outside SCREEN_W x SCREEN_H.
module render_dispatcher
    import render_dispatcher_pkg::*;
#(
    parameter int NUM_ENGINES = 2,
    parameter int FIFO_DEPTH  = 8,
    parameter int PAYLOAD_W   = 40,
    parameter int X_W         = X_W_DEF,
    parameter int Y_W         = Y_W_DEF,
    parameter int COLOR_W     = COLOR_W_DEF,
    parameter int SCREEN_W    = 160,
    parameter int SCREEN_H    = 120
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         flush,
    render_dispatcher_if.slave           cmd,
    output logic [NUM_ENGINES-1:0]       eng_enable,
    output logic [PAYLOAD_W-1:0]         eng_payload,
    input  logic [NUM_ENGINES-1:0]       eng_finished,
    input  logic [NUM_ENGINES-1:0]       eng_plot,
    input  logic [NUM_ENGINES*X_W-1:0]   eng_x,
    input  logic [NUM_ENGINES*Y_W-1:0]   eng_y,
    input  logic [NUM_ENGINES*COLOR_W-1:0] eng_color,
    output logic [X_W-1:0]               out_x,
    output logic [Y_W-1:0]               out_y,
    output logic [COLOR_W-1:0]           out_color,
    output logic                         plot,
    output logic                         busy,
    output logic                         cmd_err
);
    localparam int ENG_W   = idx_w(NUM_ENGINES);
    localparam int ENTRY_W = ENG_W + PAYLOAD_W;
`ifdef RENDER_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    disp_state_e          state_q, state_d;
    logic [ENG_W-1:0]     sel_q, sel_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;
    logic                 err_q, err_d;
    logic                 plot_q, plot_d;
    logic [X_W-1:0]       out_x_q;
    logic [Y_W-1:0]       out_y_q;
    logic [COLOR_W-1:0]   out_color_q;

    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic               idx_ok, accept;

    // Bad engine indices are consumed off the channel but never reach the queue
    assign idx_ok    = ({1'b0, cmd.cmd_engine} < (ENG_W+1)'(NUM_ENGINES));
    assign accept    = cmd.cmd_valid & cmd.cmd_ready & ~flush;
    assign fifo_push = accept & idx_ok;
    assign err_d     = accept & ~idx_ok;
    assign cmd.cmd_ready = ~fifo_full;

    render_dispatcher_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_cmd_fifo (
        .clock  (clock),
        .resetn (resetn),
        .flush  (flush),
        .push   (fifo_push),
        .wdata  ({cmd.cmd_engine, cmd.cmd_payload}),
        .pop    (fifo_pop),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        payload_d = payload_q;
        fifo_pop  = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        sel_d     = fifo_rdata[ENTRY_W-1 -: ENG_W];
                        payload_d = fifo_rdata[PAYLOAD_W-1:0];
                        state_d   = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (eng_finished[sel_q]) state_d = ST_RELEASE;
                end
                ST_RELEASE: state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        eng_enable = '0;
        if (state_q == ST_RUN) eng_enable[sel_q] = 1'b1;
    end

    logic [X_W-1:0]     sel_x;
    logic [Y_W-1:0]     sel_y;
    logic [COLOR_W-1:0] sel_color;
    logic               in_bounds;

    assign sel_x     = eng_x[int'(sel_q)*X_W +: X_W];
    assign sel_y     = eng_y[int'(sel_q)*Y_W +: Y_W];
    assign sel_color = eng_color[int'(sel_q)*COLOR_W +: COLOR_W];
    assign in_bounds = (int'(sel_x) < SCREEN_W) && (int'(sel_y) < SCREEN_H);
    assign plot_d    = ~flush & (state_q == ST_RUN) & eng_plot[sel_q] & (~CLIP_EN | in_bounds);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            payload_q   <= '0;
            err_q       <= 1'b0;
            plot_q      <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_color_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            payload_q <= payload_d;
            err_q     <= err_d;
            plot_q    <= plot_d;
            // Coordinates only move with a real plot so the VGA side sees a stable pixel
            if (plot_d) begin
                out_x_q     <= sel_x;
                out_y_q     <= sel_y;
                out_color_q <= sel_color;
            end
        end
    end

    assign eng_payload = payload_q;
    assign cmd_err     = err_q;
    assign plot        = plot_q;
    assign out_x       = out_x_q;
    assign out_y       = out_y_q;
    assign out_color   = out_color_q;
    assign busy        = (state_q != ST_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_render_dispatcher.sv
// tb/tb_render_dispatcher.sv - directed and randomized checks of render_dispatcher against a queue model
module tb_render_dispatcher;
    import render_dispatcher_pkg::*;

    localparam int NE    = 3;
    localparam int DEPTH = 8;
    localparam int PW    = 40;
    localparam int XW    = X_W_DEF;
    localparam int YW    = Y_W_DEF;
    localparam int CW    = COLOR_W_DEF;
    localparam int SW    = 160;
    localparam int SH    = 120;
    localparam int EW    = idx_w(NE);
`ifdef RENDER_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    typedef struct packed {
        logic [EW-1:0] eng;
        logic [PW-1:0] pl;
    } cmd_t;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    logic flush  = 1'b0;

    logic [NE-1:0]    eng_enable;
    logic [PW-1:0]    eng_payload;
    logic [NE-1:0]    eng_finished = '0;
    logic [NE-1:0]    eng_plot     = '0;
    logic [NE*XW-1:0] eng_x        = '0;
    logic [NE*YW-1:0] eng_y        = '0;
    logic [NE*CW-1:0] eng_color    = '0;
    logic [XW-1:0]    out_x;
    logic [YW-1:0]    out_y;
    logic [CW-1:0]    out_color;
    logic             plot, busy, cmd_err;

    render_dispatcher_if #(.ENG_W(EW), .PAYLOAD_W(PW)) cmd_if ();

    render_dispatcher #(
        .NUM_ENGINES (NE),
        .FIFO_DEPTH  (DEPTH),
        .PAYLOAD_W   (PW),
        .X_W         (XW),
        .Y_W         (YW),
        .COLOR_W     (CW),
        .SCREEN_W    (SW),
        .SCREEN_H    (SH)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .flush        (flush),
        .cmd          (cmd_if),
        .eng_enable   (eng_enable),
        .eng_payload  (eng_payload),
        .eng_finished (eng_finished),
        .eng_plot     (eng_plot),
        .eng_x        (eng_x),
        .eng_y        (eng_y),
        .eng_color    (eng_color),
        .out_x        (out_x),
        .out_y        (out_y),
        .out_color    (out_color),
        .plot         (plot),
        .busy         (busy),
        .cmd_err      (cmd_err)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    int   n_pass   = 0;
    int   n_checks = 0;
    cmd_t exp_q[$];
    cmd_t cur;
    logic [XW-1:0] last_x = '0;
    logic [YW-1:0] last_y = '0;
    logic [CW-1:0] last_c = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [NE-1:0] onehot(input logic [EW-1:0] e);
        logic [NE-1:0] r;
        r = '0;
        r[e] = 1'b1;
        return r;
    endfunction

    function automatic logic [PW-1:0] make_pl();
        logic [PW-1:0] p;
        p = PW'({$urandom(), $urandom()});
        p[PL_X_LSB +: XW]     = XW'($urandom());
        p[PL_Y_LSB +: YW]     = YW'($urandom());
        p[PL_SIZE_LSB +: 16]  = 16'($urandom());
        p[PL_COLOR_LSB +: CW] = CW'($urandom());
        return p;
    endfunction

    // Model: queue accepts while fewer than DEPTH commands wait; bad indices are dropped with an error
    task automatic push(input logic [EW-1:0] e, input logic [PW-1:0] p);
        bit   exp_rdy;
        cmd_t c;
        exp_rdy = (exp_q.size() < DEPTH);
        cmd_if.cmd_valid   = 1'b1;
        cmd_if.cmd_engine  = e;
        cmd_if.cmd_payload = p;
        check("cmd_ready", cmd_if.cmd_ready, exp_rdy);
        tick();
        cmd_if.cmd_valid = 1'b0;
        check("cmd_err", cmd_err, exp_rdy && int'(e) >= NE);
        if (exp_rdy && int'(e) < NE) begin
            c.eng = e;
            c.pl  = p;
            exp_q.push_back(c);
        end
    endtask

    task automatic start_next();
        int w;
        w = 0;
        while (eng_enable == '0 && w < 20) begin
            tick();
            w++;
        end
        check("dispatch_wait", eng_enable != '0, 1);
        cur = exp_q.pop_front();
        check("enable_sel", eng_enable, onehot(cur.eng));
        check("eng_payload", eng_payload, cur.pl);
    endtask

    task automatic rand_pix();
        eng_x     = (NE*XW)'({$urandom(), $urandom()});
        eng_y     = (NE*YW)'({$urandom(), $urandom()});
        eng_color = (NE*CW)'($urandom());
    endtask

    // Only the running engine's strobe reaches the VGA port, one cycle later
    task automatic pix_step(input logic [NE-1:0] mask);
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [CW-1:0] c;
        bit            exp_plot;
        x = eng_x[int'(cur.eng)*XW +: XW];
        y = eng_y[int'(cur.eng)*YW +: YW];
        c = eng_color[int'(cur.eng)*CW +: CW];
        exp_plot = mask[cur.eng] && (!CLIP || (int'(x) < SW && int'(y) < SH));
        eng_plot = mask;
        tick();
        eng_plot = '0;
        if (exp_plot) begin
            last_x = x;
            last_y = y;
            last_c = c;
        end
        check("plot", plot, exp_plot);
        check("out_x", out_x, last_x);
        check("out_y", out_y, last_y);
        check("out_color", out_color, last_c);
        check("enable_hold", eng_enable, onehot(cur.eng));
    endtask

    task automatic finish_cur(input int hold);
        for (int i = 0; i < hold; i++) begin
            rand_pix();
            eng_finished = NE'($urandom()) & ~onehot(cur.eng);
            pix_step(NE'($urandom()));
        end
        eng_finished = onehot(cur.eng);
        tick();
        check("release_enable", eng_enable, 0);
        check("release_busy", busy, 1);
        eng_finished = '0;
        eng_plot     = onehot(cur.eng);
        tick();
        eng_plot = '0;
        check("gap_enable", eng_enable, 0);
        check("no_plot_outside_run", plot, 0);
    endtask

    initial begin
        cmd_if.cmd_valid   = 1'b0;
        cmd_if.cmd_engine  = '0;
        cmd_if.cmd_payload = '0;

        // Reset state
        tick();
        tick();
        check("rst_cmd_ready", cmd_if.cmd_ready, 1);
        check("rst_enable", eng_enable, 0);
        check("rst_payload", eng_payload, 0);
        check("rst_plot", plot, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_err", cmd_err, 0);
        check("rst_out_x", out_x, 0);
        resetn = 1'b1;
        tick();

        // Single text command held for ten cycles before finishing
        push(EW'(ENG_TEXT), make_pl());
        check("t1_busy_queued", busy, 1);
        check("t1_enable_queued", eng_enable, 0);
        start_next();
        finish_cur(10);
        check("t1_busy_done", busy, 0);

        // Fill the queue behind a stalled engine, then drain in order
        push(EW'(ENG_TEXT), make_pl());
        start_next();
        for (int i = 0; i < DEPTH; i++) push(EW'($urandom_range(0, NE-1)), make_pl());
        check("t2_full_ready", cmd_if.cmd_ready, 0);
        push(EW'(ENG_RECT), make_pl());
        finish_cur(1);
        start_next();
        check("t2_ready_back", cmd_if.cmd_ready, 1);
        finish_cur(2);
        while (exp_q.size() > 0) begin
            start_next();
            finish_cur($urandom_range(0, 3));
        end
        check("t2_busy_done", busy, 0);

        // Out-of-range engine index
        push(EW'(3), make_pl());
        check("t3_enable", eng_enable, 0);
        check("t3_busy", busy, 0);
        tick();
        check("t3_err_pulse_end", cmd_err, 0);
        check("t3_enable_later", eng_enable, 0);

        // Strobe arbitration and clipping boundary on the rect engine
        push(EW'(ENG_RECT), make_pl());
        start_next();
        eng_x = '0; eng_y = '0; eng_color = '0;
        eng_x[0 +: XW] = 8'd5;   eng_y[0 +: YW] = 7'd3;  eng_color[0 +: CW] = 3'd1;
        eng_x[XW +: XW] = 8'd9;  eng_y[YW +: YW] = 7'd4; eng_color[CW +: CW] = 3'd6;
        pix_step(3'b011);
        check("t4_out_x_is_9", out_x, 9);
        eng_x[0 +: XW] = 8'd7;
        pix_step(3'b001);
        eng_x[XW +: XW] = 8'd160; eng_y[YW +: YW] = 7'd10;
        pix_step(3'b010);
        eng_x[XW +: XW] = 8'd159; eng_y[YW +: YW] = 7'd119;
        pix_step(3'b010);
        check("t6_corner_plot", plot, 1);
        finish_cur(0);

        // Flush while running with three waiting, plus a push and strobe in the flush cycle
        push(EW'(ENG_TEXT), make_pl());
        start_next();
        for (int i = 0; i < 3; i++) push(EW'($urandom_range(0, NE-1)), make_pl());
        flush = 1'b1;
        cmd_if.cmd_valid   = 1'b1;
        cmd_if.cmd_engine  = EW'(ENG_RECT);
        cmd_if.cmd_payload = make_pl();
        eng_plot = onehot(cur.eng);
        tick();
        flush = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        eng_plot = '0;
        exp_q.delete();
        check("t5_enable", eng_enable, 0);
        check("t5_busy", busy, 0);
        check("t5_plot", plot, 0);
        check("t5_ready", cmd_if.cmd_ready, 1);
        check("t5_out_hold", out_x, last_x);
        tick(); tick(); tick();
        check("t5_idle_after", eng_enable, 0);
        push(EW'(ENG_RECT), make_pl());
        push(EW'(ENG_TEXT), make_pl());
        while (exp_q.size() > 0) begin
            start_next();
            finish_cur($urandom_range(0, 3));
        end
        check("t5_busy_done", busy, 0);

        // Random bursts including bad indices
        for (int b = 0; b < 8; b++) begin
            int k;
            k = $urandom_range(1, 4);
            for (int j = 0; j < k; j++) push(EW'($urandom_range(0, 3)), make_pl());
            while (exp_q.size() > 0) begin
                start_next();
                finish_cur($urandom_range(0, 5));
            end
            check("rnd_busy_done", busy, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
